rl_pair_generator: RTL and testbench

Producer side of the range-limited force pipeline. Walks every reference particle of the home cell against the same-index neighbor particle in each of NUM_FILTER neighbor-cell position memories and drives the pair inputs of the RL force evaluation unit. Stops issuing new pairs while any filter asserts back-pressure. Advances to the next reference particle only after the filter bank reports all buffers empty, so force accumulation never mixes two references.

---
 rtl/rl_pkg.sv | 23 ++
 rtl/rl_pair_generator.sv | 207 ++++++++++++++++++++
 tb/tb_rl_pair_generator.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rl_pkg.sv
// -----------------------------------------------------------------------------
// rl_pkg
//   Shared definitions for the range-limited force pipeline: the pair
//   generator FSM state type and the particle index / count widths used by
//   the generator and by the force unit's consumers.
// -----------------------------------------------------------------------------
package rl_pkg;

  // Particle index width within a cell; counts need one extra bit so that a
  // completely full cell (2^PARTICLE_ID_WIDTH particles) is representable.
  localparam int PARTICLE_ID_WIDTH = 7;
  localparam int COUNT_WIDTH       = PARTICLE_ID_WIDTH + 1;

  typedef enum logic [2:0] {
    GEN_IDLE,
    GEN_REF_ADDR,
    GEN_REF_WAIT,
    GEN_STREAM,
    GEN_DRAIN,
    GEN_DONE
  } gen_state_t;

endpackage : rl_pkg

// File: rtl/rl_pair_generator.sv
// -----------------------------------------------------------------------------
// rl_pair_generator
//   Producer side of the range-limited force pipeline. For every reference
//   particle of the home cell it streams the same-index neighbor particle of
//   each of NUM_FILTER neighbor-cell position memories to the filters.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle run request, honoured only when idle
//   ref_count         home-cell particle count (stable for the run)
//   nb_count          per-filter neighbor-cell counts (stable for the run)
//   ref_rd_addr/data  home-cell position memory, 1-cycle read latency
//   nb_rd_addr/data   shared address / per-filter {z,y,x} neighbor positions
//   pair_valid        per-filter pair strobe
//   ref/nb_particle_id indices of the pair on the outputs
//   ref_x/y/z         reference position replicated per filter
//   nb_x/y/z          per-filter neighbor positions
//   back_pressure     per-filter almost-full; any bit stalls issue
//   all_buffer_empty  filter bank drained; trusted only after the drain guard
//   busy, done        run in progress / one-cycle end-of-run pulse
// -----------------------------------------------------------------------------
module rl_pair_generator #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = rl_pkg::PARTICLE_ID_WIDTH,
  parameter int NUM_FILTER        = 7,
  parameter int DRAIN_GUARD       = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [PARTICLE_ID_WIDTH:0]                  ref_count,
  input  logic [NUM_FILTER*(PARTICLE_ID_WIDTH+1)-1:0] nb_count,
  output logic [PARTICLE_ID_WIDTH-1:0]                ref_rd_addr,
  input  logic [3*DATA_WIDTH-1:0]                     ref_rd_data,
  output logic [PARTICLE_ID_WIDTH-1:0]                nb_rd_addr,
  input  logic [NUM_FILTER*3*DATA_WIDTH-1:0]          nb_rd_data,
  output logic [NUM_FILTER-1:0]                       pair_valid,
  output logic [PARTICLE_ID_WIDTH-1:0]                ref_particle_id,
  output logic [PARTICLE_ID_WIDTH-1:0]                nb_particle_id,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]            ref_x,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]            ref_y,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]            ref_z,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]            nb_x,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]            nb_y,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]            nb_z,
  input  logic [NUM_FILTER-1:0]                       back_pressure,
  input  logic                                        all_buffer_empty,
  output logic                                        busy,
  output logic                                        done
);

  import rl_pkg::*;

  localparam int DW    = DATA_WIDTH;
  localparam int PW    = PARTICLE_ID_WIDTH;
  localparam int CNT_W = PARTICLE_ID_WIDTH + 1;
  localparam int DCW   = (DRAIN_GUARD > 0) ? $clog2(DRAIN_GUARD + 1) : 1;
  localparam logic [DCW-1:0] GUARD = DCW'(DRAIN_GUARD);

  gen_state_t               state_q, state_d;
  logic [CNT_W-1:0]         nb_max;
  logic [CNT_W-1:0]         nb_max_q, nb_max_d;
  logic [CNT_W-1:0]         ref_idx_q, ref_idx_d;
  logic [CNT_W-1:0]         nb_idx_q, nb_idx_d;
  logic [DCW-1:0]           drain_cnt_q, drain_cnt_d;
  logic [3*DW-1:0]          ref_pos_q, ref_pos_d;
  // Issue stage: marks that an address went to the memories last cycle.
  logic                     iss_vld_q, iss_vld_d;
  logic [CNT_W-1:0]         iss_idx_q, iss_idx_d;
  // Output stage.
  logic [NUM_FILTER-1:0]    pair_valid_q, pair_valid_d;
  logic [PW-1:0]            ref_pid_q, ref_pid_d;
  logic [PW-1:0]            nb_pid_q, nb_pid_d;
  logic [NUM_FILTER*3*DW-1:0] nb_pos_q, nb_pos_d;

  logic issue, last_idx, last_ref, drain_ok;

  // Longest neighbor list; captured at start so the stream length is fixed
  // for the whole run.
  always_comb begin
    nb_max = '0;
    for (int f = 0; f < NUM_FILTER; f++) begin
      if (nb_count[f*CNT_W +: CNT_W] > nb_max) nb_max = nb_count[f*CNT_W +: CNT_W];
    end
  end

  assign last_idx = (nb_idx_q == nb_max_q - CNT_W'(1));
  assign last_ref = (ref_idx_q == ref_count - CNT_W'(1));
  // The guard covers pairs still in flight that the filters have not yet
  // counted in all_buffer_empty.
  assign drain_ok = (drain_cnt_q >= GUARD) && all_buffer_empty;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      GEN_IDLE:     if (start) state_d = (ref_count == '0) ? GEN_DONE : GEN_REF_ADDR;
      GEN_REF_ADDR: state_d = GEN_REF_WAIT;
      GEN_REF_WAIT: state_d = (nb_max_q == '0) ? GEN_DRAIN : GEN_STREAM;
      GEN_STREAM:   if (issue && last_idx) state_d = GEN_DRAIN;
      GEN_DRAIN:    if (drain_ok) state_d = last_ref ? GEN_DONE : GEN_REF_ADDR;
      GEN_DONE:     state_d = GEN_IDLE;
      default:      state_d = GEN_IDLE;
    endcase
  end

  always_comb begin
    issue = (state_q == GEN_STREAM) && (back_pressure == '0);
    busy  = (state_q != GEN_IDLE);
    done  = (state_q == GEN_DONE);
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    nb_max_d    = nb_max_q;
    ref_idx_d   = ref_idx_q;
    nb_idx_d    = nb_idx_q;
    drain_cnt_d = '0;
    ref_pos_d   = ref_pos_q;

    if ((state_q == GEN_IDLE) && start) begin
      nb_max_d  = nb_max;
      ref_idx_d = '0;
    end
    if (state_q == GEN_REF_WAIT) begin
      ref_pos_d = ref_rd_data;
      nb_idx_d  = '0;
    end
    if (issue) nb_idx_d = nb_idx_q + CNT_W'(1);
    if (state_q == GEN_DRAIN) begin
      drain_cnt_d = (drain_cnt_q < GUARD) ? drain_cnt_q + DCW'(1) : drain_cnt_q;
      if (drain_ok && !last_ref) ref_idx_d = ref_idx_q + CNT_W'(1);
    end
  end

  always_comb begin
    iss_vld_d  = issue;
    iss_idx_d  = issue ? nb_idx_q : iss_idx_q;
    ref_pid_d  = ref_pid_q;
    nb_pid_d   = nb_pid_q;
    nb_pos_d   = nb_pos_q;
    for (int f = 0; f < NUM_FILTER; f++) begin
      // Filter 0 reads the home cell, so the same index there is the
      // reference itself.
      pair_valid_d[f] = iss_vld_q && (iss_idx_q < nb_count[f*CNT_W +: CNT_W]) &&
                        !((f == 0) && (iss_idx_q == ref_idx_q));
    end
    if (iss_vld_q) begin
      nb_pos_d  = nb_rd_data;
      nb_pid_d  = iss_idx_q[PW-1:0];
      ref_pid_d = ref_idx_q[PW-1:0];
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= GEN_IDLE;
      nb_max_q     <= '0;
      ref_idx_q    <= '0;
      nb_idx_q     <= '0;
      drain_cnt_q  <= '0;
      ref_pos_q    <= '0;
      iss_vld_q    <= 1'b0;
      iss_idx_q    <= '0;
      pair_valid_q <= '0;
      ref_pid_q    <= '0;
      nb_pid_q     <= '0;
      nb_pos_q     <= '0;
    end else begin
      state_q      <= state_d;
      nb_max_q     <= nb_max_d;
      ref_idx_q    <= ref_idx_d;
      nb_idx_q     <= nb_idx_d;
      drain_cnt_q  <= drain_cnt_d;
      ref_pos_q    <= ref_pos_d;
      iss_vld_q    <= iss_vld_d;
      iss_idx_q    <= iss_idx_d;
      pair_valid_q <= pair_valid_d;
      ref_pid_q    <= ref_pid_d;
      nb_pid_q     <= nb_pid_d;
      nb_pos_q     <= nb_pos_d;
    end
  end

  // ------------------------------------------------------------ outputs
  // Addresses come straight from the index registers; the memories register
  // them, giving the one-cycle read latency the pipeline is built around.
  assign ref_rd_addr     = ref_idx_q[PW-1:0];
  assign nb_rd_addr      = nb_idx_q[PW-1:0];
  assign pair_valid      = pair_valid_q;
  assign ref_particle_id = ref_pid_q;
  assign nb_particle_id  = nb_pid_q;

  for (genvar f = 0; f < NUM_FILTER; f++) begin : g_fan
    assign ref_x[f*DW +: DW] = ref_pos_q[0    +: DW];
    assign ref_y[f*DW +: DW] = ref_pos_q[DW   +: DW];
    assign ref_z[f*DW +: DW] = ref_pos_q[2*DW +: DW];
    assign nb_x[f*DW +: DW]  = nb_pos_q[f*3*DW        +: DW];
    assign nb_y[f*DW +: DW]  = nb_pos_q[f*3*DW + DW   +: DW];
    assign nb_z[f*DW +: DW]  = nb_pos_q[f*3*DW + 2*DW +: DW];
  end

endmodule : rl_pair_generator

// File: tb/tb_rl_pair_generator.sv
// -----------------------------------------------------------------------------
// tb_rl_pair_generator
//   Randomised bench for rl_pair_generator. Position memories hold random
//   data; the expected pair sequence is derived from the counts alone and
//   compared in order against every cycle that carries a pair.
// -----------------------------------------------------------------------------
module tb_rl_pair_generator;

  localparam int DW = 32;
  localparam int PW = 7;
  localparam int CW = PW + 1;
  localparam int NF = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CW-1:0]     ref_count;
  logic [NF*CW-1:0]  nb_count;
  logic [PW-1:0]     ref_rd_addr;
  logic [3*DW-1:0]   ref_rd_data;
  logic [PW-1:0]     nb_rd_addr;
  logic [NF*3*DW-1:0] nb_rd_data;
  logic [NF-1:0]     pair_valid;
  logic [PW-1:0]     ref_particle_id, nb_particle_id;
  logic [NF*DW-1:0]  ref_x, ref_y, ref_z, nb_x, nb_y, nb_z;
  logic [NF-1:0]     back_pressure;
  logic              all_buffer_empty;
  logic              busy, done;

  rl_pair_generator #(
    .DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(PW), .NUM_FILTER(NF), .DRAIN_GUARD(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ref_count(ref_count), .nb_count(nb_count),
    .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .nb_rd_addr(nb_rd_addr), .nb_rd_data(nb_rd_data),
    .pair_valid(pair_valid), .ref_particle_id(ref_particle_id),
    .nb_particle_id(nb_particle_id),
    .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z),
    .nb_x(nb_x), .nb_y(nb_y), .nb_z(nb_z),
    .back_pressure(back_pressure), .all_buffer_empty(all_buffer_empty),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Position memories, 1-cycle read latency.
  logic [3*DW-1:0] ref_mem [128];
  logic [3*DW-1:0] nb_mem  [NF][128];

  always @(posedge clk) begin
    ref_rd_data <= ref_mem[ref_rd_addr];
    for (int f = 0; f < NF; f++) nb_rd_data[f*3*DW +: 3*DW] <= nb_mem[f][nb_rd_addr];
  end

  // ------------------------------------------------------------ checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  typedef struct {
    logic [NF-1:0]    mask;
    logic [PW-1:0]    rid, nid;
    logic [NF*DW-1:0] nx, ny, nz, rx, ry, rz;
  } pair_t;

  pair_t sb[$];
  int    cfg_rc;
  int    cfg_nb [NF];

  // Every reference meets every neighbor index up to the longest list;
  // a filter takes part when its cell holds that index, except the home
  // cell's own reference. Index slots no filter takes are invisible.
  task automatic build_expected();
    int mx;
    pair_t e;
    mx = 0;
    sb.delete();
    for (int f = 0; f < NF; f++) if (cfg_nb[f] > mx) mx = cfg_nb[f];
    for (int r = 0; r < cfg_rc; r++) begin
      for (int i = 0; i < mx; i++) begin
        e.mask = '0;
        for (int f = 0; f < NF; f++)
          e.mask[f] = (i < cfg_nb[f]) && !(f == 0 && i == r);
        if (e.mask != '0) begin
          e.rid = PW'(r);
          e.nid = PW'(i);
          for (int f = 0; f < NF; f++) begin
            e.nx[f*DW +: DW] = nb_mem[f][i][DW-1:0];
            e.ny[f*DW +: DW] = nb_mem[f][i][2*DW-1:DW];
            e.nz[f*DW +: DW] = nb_mem[f][i][3*DW-1:2*DW];
            e.rx[f*DW +: DW] = ref_mem[r][DW-1:0];
            e.ry[f*DW +: DW] = ref_mem[r][2*DW-1:DW];
            e.rz[f*DW +: DW] = ref_mem[r][3*DW-1:2*DW];
          end
          sb.push_back(e);
        end
      end
    end
  endtask

  // ------------------------------------------------------------ monitor
  int pair_cycles = 0;
  int f0_pairs    = 0;
  int done_cnt    = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt <= done_cnt + 1;
      if (|pair_valid) begin
        pair_cycles <= pair_cycles + 1;
        if (pair_valid[0]) f0_pairs <= f0_pairs + 1;
        if (sb.size() == 0) begin
          check("extra_pair", pair_valid, '0);
        end else begin
          check("mask",   pair_valid,      sb[0].mask);
          check("ref_id", ref_particle_id, sb[0].rid);
          check("nb_id",  nb_particle_id,  sb[0].nid);
          check("nb_x",   nb_x, sb[0].nx);
          check("nb_y",   nb_y, sb[0].ny);
          check("nb_z",   nb_z, sb[0].nz);
          check("ref_xyz", {ref_x ^ ref_y, ref_z}, {sb[0].rx ^ sb[0].ry, sb[0].rz});
          sb.pop_front();
        end
      end
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic run_start();
    for (int a = 0; a < 128; a++) begin
      ref_mem[a] = {$urandom, $urandom, $urandom};
      for (int f = 0; f < NF; f++) nb_mem[f][a] = {$urandom, $urandom, $urandom};
    end
    ref_count = CW'(cfg_rc);
    for (int f = 0; f < NF; f++) nb_count[f*CW +: CW] = CW'(cfg_nb[f]);
    build_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_sb_left"}, sb.size(), 0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic first_pair(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (|pair_valid) break;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {pair_valid, busy, done, ref_rd_addr, nb_rd_addr,
                          ref_particle_id, nb_particle_id}, '0);
    check({tag, "_nb"},  nb_x | nb_y | nb_z, '0);
    check({tag, "_ref"}, ref_x | ref_y | ref_z, '0);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int pc0, f00, d0, c0, lat;
    rst = 1'b1; start = 1'b0; ref_count = '0; nb_count = '0;
    back_pressure = '0; all_buffer_empty = 1'b1;
    #23;
    check_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Basic run: 3 references x 4 neighbors, self-pairs skipped on filter 0.
    cfg_rc = 3;
    for (int f = 0; f < NF; f++) cfg_nb[f] = 4;
    pc0 = pair_cycles; f00 = f0_pairs; d0 = done_cnt;
    run_start();
    first_pair(lat);
    check("first_latency", lat, 4);
    wait_done("basic", d0);
    check("basic_pairs", pair_cycles - pc0, 12);
    check("basic_f0_pairs", f0_pairs - f00, 9);

    // Ragged neighbor counts: stream length follows the longest list.
    cfg_rc = 2;
    for (int f = 0; f < NF; f++) cfg_nb[f] = f + 1;
    pc0 = pair_cycles; d0 = done_cnt;
    run_start();
    wait_done("ragged", d0);
    check("ragged_pairs", pair_cycles - pc0, 14);

    // Back-pressure on one filter for 5 cycles mid-stream.
    cfg_rc = 2;
    for (int f = 0; f < NF; f++) cfg_nb[f] = 16;
    pc0 = pair_cycles; d0 = done_cnt;
    run_start();
    first_pair(lat);
    repeat (2) @(posedge clk);
    #1 back_pressure = 7'b0001000;
    @(negedge clk); #1 c0 = pair_cycles;
    repeat (5) @(posedge clk);
    #1 back_pressure = '0;
    repeat (2) @(negedge clk);
    #1 check("bp_inflight", pair_cycles - c0, 1);
    wait_done("bp", d0);
    check("bp_pairs", pair_cycles - pc0, 32);

    // Filter bank not empty: the reference must not advance.
    cfg_rc = 2;
    for (int f = 0; f < NF; f++) cfg_nb[f] = 2;
    all_buffer_empty = 1'b0;
    d0 = done_cnt;
    run_start();
    repeat (30) @(negedge clk);
    check("drain_hold", {busy, 1'b0, ref_rd_addr}, {1'b1, 1'b0, 7'd0});
    @(posedge clk); #1 all_buffer_empty = 1'b1;
    @(negedge clk) check("drain_pre", ref_rd_addr, 7'd0);
    @(posedge clk); #1 check("drain_adv", ref_rd_addr, 7'd1);
    wait_done("drain", d0);

    // Empty home cell: straight to done, no pairs.
    cfg_rc = 0;
    pc0 = pair_cycles;
    run_start();
    @(negedge clk) check("rc0_done", done, 1'b1);
    @(negedge clk) check("rc0_done_end", {done, busy}, 2'b00);
    #1 check("rc0_pairs", pair_cycles - pc0, 0);

    // Empty neighbor cells: every reference drains, no pairs.
    cfg_rc = 2;
    for (int f = 0; f < NF; f++) cfg_nb[f] = 0;
    pc0 = pair_cycles; d0 = done_cnt;
    run_start();
    wait_done("nb0", d0);
    check("nb0_pairs", pair_cycles - pc0, 0);

    // Reset mid-stream aborts without done; the next run starts clean.
    cfg_rc = 3;
    for (int f = 0; f < NF; f++) cfg_nb[f] = 8;
    d0 = done_cnt;
    run_start();
    first_pair(lat);
    @(posedge clk); #2 rst = 1'b1;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    #1 check("midrst_no_done", done_cnt - d0, 0);
    cfg_rc = 2;
    for (int f = 0; f < NF; f++) cfg_nb[f] = 5;
    pc0 = pair_cycles; d0 = done_cnt;
    run_start();
    wait_done("rerun", d0);
    check("rerun_pairs", pair_cycles - pc0, 10);

    // Random counts with random back-pressure and random buffer status.
    for (int it = 0; it < 4; it++) begin
      int n;
      cfg_rc = $urandom_range(1, 4);
      for (int f = 0; f < NF; f++) cfg_nb[f] = $urandom_range(0, 12);
      d0 = done_cnt;
      run_start();
      n = 0;
      while (done_cnt == d0 && n < 3000) begin
        @(posedge clk); #1;
        back_pressure    = ($urandom_range(0, 2) == 0) ? 7'($urandom) : '0;
        all_buffer_empty = 1'($urandom_range(0, 1));
        n++;
      end
      back_pressure = '0;
      all_buffer_empty = 1'b1;
      wait_done("rand", d0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rl_pair_generator
